// File: rtl/add_hold_sequencer_if.sv
// Control bundle between decode/arbiter logic and the reg_ADD_HOLD sequencer.
// The master side issues commands and grants; the slave side is the sequencer.
interface add_hold_sequencer_if;
    logic       START;
    logic [1:0] DEST;
    logic       READY;
    logic       DONE;
    logic       ERROR;
    logic       ALU_LOAD;
    logic       ADL_BUS_ENABLE;
    logic       SB_L_BUS_ENABLE;
    logic       SB_H_BUS_ENABLE;
    logic       SB_REQ;
    logic       SB_GNT;

    modport master (
        output START, DEST, SB_GNT,
        input  READY, DONE, ERROR, ALU_LOAD, ADL_BUS_ENABLE,
               SB_L_BUS_ENABLE, SB_H_BUS_ENABLE, SB_REQ
    );

    modport slave (
        input  START, DEST, SB_GNT,
        output READY, DONE, ERROR, ALU_LOAD, ADL_BUS_ENABLE,
               SB_L_BUS_ENABLE, SB_H_BUS_ENABLE, SB_REQ
    );
endinterface

// File: rtl/add_hold_sequencer.sv
// Sequences ALU_LOAD, ADL and SB drive strobes for the adder hold register,
// arbitrating for the shared SB bus before driving it.
module add_hold_sequencer #(
    parameter int unsigned DRIVE_CYCLES = 1,
    parameter int unsigned GNT_TIMEOUT  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    add_hold_sequencer_if.slave  bus
);

    localparam int unsigned DRV_W  = 4;
    localparam int unsigned WAIT_W = 8;
    localparam logic [DRV_W-1:0]  DRV_LAST  = DRV_W'(DRIVE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GNT_TIMEOUT - 1);

    localparam logic [1:0] DEST_ADL    = 2'b00;
    localparam logic [1:0] DEST_SB_LO  = 2'b10;
    localparam logic [1:0] DEST_ADL_SB = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADL,
        S_SB_ARB,
        S_SB_DRIVE,
        S_DONE,
        S_FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         dest_q, dest_d;
    logic [DRV_W-1:0]   drv_cnt_q, drv_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic ready_q, ready_d;
    logic done_q, done_d;
    logic error_q, error_d;
    logic alu_load_q, alu_load_d;
    logic adl_en_q, adl_en_d;
    logic sb_l_en_q, sb_l_en_d;
    logic sb_h_en_q, sb_h_en_d;
    logic sb_req_q, sb_req_d;

    // Next state, counters, and outputs decoded from the next state so they are flop outputs.
    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        drv_cnt_d  = '0;
        wait_cnt_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    dest_d  = bus.DEST;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if ((dest_q == DEST_ADL) || (dest_q == DEST_ADL_SB)) begin
                    state_d = S_ADL;
                end else begin
                    state_d = S_SB_ARB;
                end
            end
            S_ADL: begin
                if (drv_cnt_q == DRV_LAST) begin
                    state_d = (dest_q == DEST_ADL_SB) ? S_SB_ARB : S_DONE;
                end else begin
                    drv_cnt_d = drv_cnt_q + DRV_W'(1);
                end
            end
            S_SB_ARB: begin
                // A grant on the final edge of the window beats the timeout.
                if (bus.SB_GNT) begin
                    state_d = S_SB_DRIVE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAIL;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_SB_DRIVE: begin
                if (!bus.SB_GNT) begin
                    state_d = S_FAIL;
                end else if (drv_cnt_q == DRV_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drv_cnt_d = drv_cnt_q + DRV_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d    = (state_d == S_IDLE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_FAIL);
        alu_load_d = (state_d == S_LOAD);
        adl_en_d   = (state_d == S_ADL);
        sb_req_d   = (state_d == S_SB_ARB) || (state_d == S_SB_DRIVE);
        sb_l_en_d  = (state_d == S_SB_DRIVE);
        sb_h_en_d  = (state_d == S_SB_DRIVE) && (dest_d != DEST_SB_LO);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            dest_q     <= 2'b00;
            drv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            alu_load_q <= 1'b0;
            adl_en_q   <= 1'b0;
            sb_l_en_q  <= 1'b0;
            sb_h_en_q  <= 1'b0;
            sb_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            drv_cnt_q  <= drv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
            alu_load_q <= alu_load_d;
            adl_en_q   <= adl_en_d;
            sb_l_en_q  <= sb_l_en_d;
            sb_h_en_q  <= sb_h_en_d;
            sb_req_q   <= sb_req_d;
        end
    end

    assign bus.READY           = ready_q;
    assign bus.DONE            = done_q;
    assign bus.ERROR           = error_q;
    assign bus.ALU_LOAD        = alu_load_q;
    assign bus.ADL_BUS_ENABLE  = adl_en_q;
    assign bus.SB_L_BUS_ENABLE = sb_l_en_q;
    assign bus.SB_H_BUS_ENABLE = sb_h_en_q;
    assign bus.SB_REQ          = sb_req_q;

endmodule

// File: tb/tb_add_hold_sequencer.sv
// Scoreboard bench: three sequencers (D=1,2,4) share clock and reset; per-cycle
// expected output vectors are queued as stimulus is driven and checked mid-cycle.
module tb_add_hold_sequencer;

    localparam int unsigned TMO = 8;

    // Output vector bit order: READY ALU_LOAD ADL SB_L SB_H SB_REQ DONE ERROR
    localparam logic [7:0] V_IDLE = 8'b1000_0000;
    localparam logic [7:0] V_LOAD = 8'b0100_0000;
    localparam logic [7:0] V_ADL  = 8'b0010_0000;
    localparam logic [7:0] V_ARB  = 8'b0000_0100;
    localparam logic [7:0] V_SBF  = 8'b0001_1100;
    localparam logic [7:0] V_SBL  = 8'b0001_0100;
    localparam logic [7:0] V_DONE = 8'b0000_0010;
    localparam logic [7:0] V_ERR  = 8'b0000_0001;

    typedef struct {
        int         idx;
        logic [7:0] v;
        string      tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      start_r;
    logic [2:0][1:0] dest_r;
    logic [2:0]      gnt_r;
    logic [2:0][7:0] obs;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned DC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        add_hold_sequencer_if ifc ();
        assign ifc.START  = start_r[g];
        assign ifc.DEST   = dest_r[g];
        assign ifc.SB_GNT = gnt_r[g];
        add_hold_sequencer #(.DRIVE_CYCLES(DC), .GNT_TIMEOUT(TMO)) dut (
            .CLK   (clk),
            .RESET (rst),
            .bus   (ifc.slave)
        );
        assign obs[g] = {ifc.READY, ifc.ALU_LOAD, ifc.ADL_BUS_ENABLE, ifc.SB_L_BUS_ENABLE,
                         ifc.SB_H_BUS_ENABLE, ifc.SB_REQ, ifc.DONE, ifc.ERROR};
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // One cycle of stimulus for DUT idx plus the outputs expected during that cycle.
    task automatic drive(input int idx, input logic s, input logic [1:0] d, input logic g,
                         input logic [7:0] v, input string tag);
        @(posedge clk);
        #1;
        start_r      = '0;
        start_r[idx] = s;
        dest_r[idx]  = d;
        gnt_r[idx]   = g;
        sb_q.push_back('{idx, v, tag});
    endtask

    task automatic idle(input int idx, input int n);
        for (int i = 0; i < n; i++) drive(idx, 1'b0, 2'b00, 1'b0, V_IDLE, "idle");
    endtask

    // k: cycles in SB_ARB with grant low before it rises (k >= TMO -> timeout).
    // drv_ok: if nonzero, grant is low in that drive cycle, ending the command with ERROR.
    // noise: keep START high with a different DEST while busy.
    task automatic run_cmd(input int idx, input int dcyc, input logic [1:0] dest, input int k,
                           input int drv_ok, input bit noise, input bit skip_c0);
        logic       s_b;
        logic [1:0] d_b;
        logic       g;
        bit         fail;
        s_b  = noise;
        d_b  = ~dest;
        fail = 1'b0;
        if (!skip_c0) drive(idx, 1'b1, dest, 1'b0, V_IDLE, "accept");
        drive(idx, s_b, d_b, 1'b0, V_LOAD, "load");
        if (dest == 2'b00 || dest == 2'b11)
            for (int i = 0; i < dcyc; i++) drive(idx, s_b, d_b, 1'b0, V_ADL, "adl");
        if (dest != 2'b00) begin
            if (k >= int'(TMO)) begin
                for (int i = 0; i < int'(TMO); i++) drive(idx, s_b, d_b, 1'b0, V_ARB, "arb_wait");
                fail = 1'b1;
            end else begin
                for (int i = 0; i <= k; i++) drive(idx, s_b, d_b, (i == k), V_ARB, "arb");
                for (int i = 0; i < dcyc; i++) begin
                    g = !(drv_ok > 0 && i == drv_ok - 1);
                    drive(idx, s_b, d_b, g, (dest == 2'b10) ? V_SBL : V_SBF, "sb_drive");
                    if (!g) begin
                        fail = 1'b1;
                        break;
                    end
                end
            end
        end
        drive(idx, s_b, d_b, 1'b0, fail ? V_ERR : V_DONE, fail ? "error_pulse" : "done_pulse");
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check_val(mon_e.tag, obs[mon_e.idx], mon_e.v);
        end
    end

    initial begin
        rst     = 1'b1;
        start_r = '0;
        dest_r  = '0;
        gnt_r   = '0;
        for (int i = 0; i < 3; i++) drive(i, 1'b1, 2'b11, 1'b1, V_IDLE, "reset_state");
        rst = 1'b0;
        idle(0, 1);

        run_cmd(0, 1, 2'b00, 0, 0, 1'b0, 1'b0);
        idle(0, 1);
        run_cmd(1, 2, 2'b11, 0, 0, 1'b0, 1'b0);
        idle(1, 1);
        run_cmd(0, 1, 2'b10, 3, 0, 1'b0, 1'b0);
        idle(0, 1);
        run_cmd(0, 1, 2'b01, 8, 0, 1'b0, 1'b0);
        idle(0, 1);
        run_cmd(0, 1, 2'b01, 7, 0, 1'b0, 1'b0);
        idle(0, 1);
        run_cmd(2, 4, 2'b01, 0, 2, 1'b1, 1'b0);
        idle(2, 1);
        run_cmd(2, 4, 2'b11, 2, 0, 1'b1, 1'b0);
        idle(2, 1);

        // Held START: second command accepted in the first IDLE cycle.
        run_cmd(1, 2, 2'b00, 0, 0, 1'b1, 1'b0);
        run_cmd(1, 2, 2'b10, 1, 0, 1'b1, 1'b0);
        idle(1, 1);

        // Asynchronous reset in the middle of the ADL phase.
        drive(2, 1'b1, 2'b00, 1'b0, V_IDLE, "rst_accept");
        drive(2, 1'b0, 2'b00, 1'b0, V_LOAD, "rst_load");
        drive(2, 1'b0, 2'b00, 1'b0, V_ADL, "rst_adl1");
        @(posedge clk);
        #2;
        check_val("adl_before_reset", obs[2], V_ADL);
        rst = 1'b1;
        #1;
        check_val("adl_async_drop", obs[2], V_IDLE);
        sb_q.push_back('{2, V_IDLE, "reset_hold"});
        drive(2, 1'b1, 2'b01, 1'b0, V_IDLE, "reset_hold");
        drive(2, 1'b1, 2'b00, 1'b0, V_IDLE, "reset_release");
        rst = 1'b0;
        run_cmd(2, 4, 2'b00, 0, 0, 1'b1, 1'b1);
        idle(2, 2);

        @(negedge clk);
        #1;
        check_val("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_hold_sequencer.md
# add_hold_sequencer

Sequencer for the adder hold register (reg_ADD_HOLD) in the 6502 datapath. It takes one transfer command at a time and generates the ALU_LOAD strobe and the ADL/SB bus-enable strobes in a fixed order. It requests the shared SB bus from the SB bus arbiter before driving SB, so the hold register never contends with other SB drivers. It sits between the instruction decode/timing logic and the reg_ADD_HOLD control inputs.

## Interface
- DRIVE_CYCLES, 1, cycles each bus-enable group stays asserted (legal 1..15)
- GNT_TIMEOUT, 8, cycles spent waiting for SB_GNT before aborting (legal 1..255)

- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  command strobe; accepted only when READY=1
- DEST  in  2  destination, sampled with START: 00 ADL; 01 SB full; 10 SB low 7 bits only; 11 ADL then SB full
- READY  out  1  high in IDLE only
- DONE  out  1  one-cycle pulse on successful completion
- ERROR  out  1  one-cycle pulse on grant timeout or grant loss
- ALU_LOAD  out  1  load strobe to reg_ADD_HOLD
- ADL_BUS_ENABLE  out  1  ADL drive enable to reg_ADD_HOLD
- SB_L_BUS_ENABLE  out  1  SB bits 6:0 drive enable
- SB_H_BUS_ENABLE  out  1  SB bit 7 drive enable
- SB_REQ  out  1  SB bus request to arbiter
- SB_GNT  in  1  SB bus grant from arbiter

## Operation
- States: IDLE, LOAD, ADL, SB_ARB, SB_DRIVE, DONE, FAIL. All outputs are Moore decodes of registered state; no combinational input-to-output paths.
- IDLE: READY=1. If START=1, DEST is latched into an internal register and the FSM goes to LOAD. START in any other state is ignored; DEST is not re-sampled.
- LOAD: ALU_LOAD=1 for exactly 1 cycle. Next state: ADL when DEST is 00 or 11, otherwise SB_ARB.
- ADL: ADL_BUS_ENABLE=1 for DRIVE_CYCLES cycles. Next state: SB_ARB when DEST=11, otherwise DONE.
- SB_ARB: SB_REQ=1. A wait counter clears on entry and increments each cycle.
  - SB_GNT=1 sampled at an edge: go to SB_DRIVE.
  - Otherwise, after GNT_TIMEOUT cycles in SB_ARB: go to FAIL.
  - A grant sampled at the final edge of the window wins over the timeout.
- SB_DRIVE:
  - SB_REQ=1 and SB_L_BUS_ENABLE=1 for DRIVE_CYCLES cycles.
  - SB_H_BUS_ENABLE=1 as well, unless DEST=10.
  - If SB_GNT is sampled 0 at any edge while in SB_DRIVE: go to FAIL. The enables and SB_REQ are low from the next cycle.
  - Normal exit: DONE.
- DONE: DONE=1 for 1 cycle, then IDLE. FAIL: ERROR=1 for 1 cycle, then IDLE.
- Invariants:
  - ALU_LOAD is never high together with any bus enable.
  - ADL_BUS_ENABLE is never high together with SB_L_BUS_ENABLE or SB_H_BUS_ENABLE.
  - SB_H_BUS_ENABLE=1 implies SB_L_BUS_ENABLE=1.
  - SB_L_BUS_ENABLE or SB_H_BUS_ENABLE high implies SB_REQ=1.
- Drive-cycle counter is 4 bits; wait counter is 8 bits. Both reset on state entry, so they never wrap.

## Timing
- RESET asserted: state goes to IDLE immediately, regardless of the clock. While RESET is high:
  - READY=1.
  - ALU_LOAD, ADL_BUS_ENABLE, SB_L_BUS_ENABLE, SB_H_BUS_ENABLE, SB_REQ, DONE and ERROR are all 0.
  - Latched DEST is 00 and both counters are 0.
- RESET asserted mid-operation: enables and SB_REQ drop asynchronously and no DONE/ERROR pulse is issued. A START is accepted at the first edge after release.
- Timing below uses D=DRIVE_CYCLES. Cycle 0 is the cycle in which START is sampled; cycles are counted from the edge that samples START.
- DEST=00:
  - ALU_LOAD in cycle 1.
  - ADL_BUS_ENABLE in cycles 2..1+D.
  - DONE in cycle 2+D.
  - READY high again in cycle 3+D.
- DEST=01 or 10 with SB_GNT already high:
  - SB_REQ from cycle 2.
  - SB enables in cycles 3..2+D.
  - DONE in cycle 3+D.
- DEST=11: the ADL phase (D cycles) is inserted before SB_ARB, so every SB event is D cycles later than for DEST=01.
- Grant arriving after k extra wait cycles delays every later event by k.
- Timeout: SB_ARB lasts GNT_TIMEOUT cycles, then ERROR for 1 cycle, then IDLE.
- Back-to-back commands: a START held high is accepted again in the first IDLE cycle, so there is a minimum 1-cycle READY gap between commands.

## Test plan
- D=1, DEST=00, START in cycle 0 -> ALU_LOAD=1 in cycle 1, ADL_BUS_ENABLE=1 in cycle 2 only, DONE in cycle 3; SB_REQ and both SB enables stay 0 throughout.
- D=2, DEST=11, SB_GNT tied high -> ALU_LOAD in cycle 1, ADL enable in cycles 2-3, SB_REQ from cycle 4, SB_L/SB_H enables in cycles 5-6, DONE in cycle 7; never two enable groups in the same cycle.
- D=1, DEST=10, SB_GNT rising 3 cycles after SB_REQ -> SB_L_BUS_ENABLE pulses for one cycle, SB_H_BUS_ENABLE stays 0, then DONE.
- GNT_TIMEOUT=8, DEST=01, SB_GNT held 0 -> SB_REQ high for exactly 8 cycles, ERROR pulse in the 9th, no SB enable, READY=1 next cycle; repeat with the grant arriving in the 8th cycle -> SB_DRIVE entered, no ERROR.
- D=4, DEST=01, SB_GNT dropped after 2 drive cycles -> SB enables and SB_REQ low from the next cycle, ERROR pulse, IDLE.
- RESET pulsed asynchronously during the ADL phase (D=4) -> ADL_BUS_ENABLE falls without a clock edge, no DONE; a START issued after release completes normally; START pulses while busy are ignored.
